// File: rtl/breath_pkg.sv
// Shared definitions for the breathing-brightness generator and its prescaler.
// Phase encoding is visible on the phase port, so the values are fixed.
package breath_pkg;

    localparam int DUTY_W_DEF = 4;

    typedef enum logic [1:0] {
        UP      = 2'd0,
        HOLD_HI = 2'd1,
        DOWN    = 2'd2,
        HOLD_LO = 2'd3
    } phase_e;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running step prescaler: one-cycle tick every PRESCALE_DIV enabled cycles.
// enable=0 freezes the count losslessly; clear restarts it from zero.
module tick_prescaler
    import breath_pkg::*;
#(
    parameter int PRESCALE_DIV = 4194304
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int                 CNT_W = cnt_width(PRESCALE_DIV);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(PRESCALE_DIV - 1);

    logic [CNT_W-1:0] r_pre_cnt;
    logic             w_last;

    assign w_last = (r_pre_cnt == LAST);
    assign tick   = enable & w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_cnt <= '0;
        end else if (clear) begin
            r_pre_cnt <= '0;
        end else if (enable) begin
            r_pre_cnt <= w_last ? '0 : r_pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/breath_ramp_gen.sv
// Triangular breathing duty source for the PWM stage: up, hold high, down, hold low.
// duty/phase/duty_update are registered and change on the edge that samples a tick.
module breath_ramp_gen
    import breath_pkg::*;
#(
    parameter int DUTY_W       = DUTY_W_DEF,
    parameter int PRESCALE_DIV = 4194304,
    parameter int HOLD_TICKS   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              restart,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_update,
    output logic [1:0]        phase
);

    localparam logic [DUTY_W-1:0] MAX_M1    = {{(DUTY_W-1){1'b1}}, 1'b0};
    localparam logic [DUTY_W-1:0] ONE       = DUTY_W'(1);
    localparam int                HOLD_W    = cnt_width(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLD_TICKS == 0) ? '0 : HOLD_W'(HOLD_TICKS - 1);
    // With no hold time the ramps reverse directly at the extremes.
    localparam phase_e            TOP_NEXT  = (HOLD_TICKS == 0) ? DOWN : HOLD_HI;
    localparam phase_e            BOT_NEXT  = (HOLD_TICKS == 0) ? UP   : HOLD_LO;

    logic              w_tick;
    logic [DUTY_W-1:0] r_duty;
    logic              r_duty_update;
    phase_e            r_phase;
    logic [HOLD_W-1:0] r_hold_cnt;

    tick_prescaler #(
        .PRESCALE_DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (restart),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_duty        <= '0;
            r_duty_update <= 1'b0;
            r_phase       <= UP;
            r_hold_cnt    <= '0;
        end else begin
            r_duty_update <= 1'b0;
            if (restart) begin
                r_duty        <= '0;
                r_duty_update <= (r_duty != '0);
                r_phase       <= UP;
                r_hold_cnt    <= '0;
            end else if (w_tick) begin
                case (r_phase)
                    UP: begin
                        r_duty        <= r_duty + 1'b1;
                        r_duty_update <= 1'b1;
                        r_hold_cnt    <= '0;
                        if (r_duty == MAX_M1) r_phase <= TOP_NEXT;
                    end
                    HOLD_HI: begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_phase    <= DOWN;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    DOWN: begin
                        r_duty        <= r_duty - 1'b1;
                        r_duty_update <= 1'b1;
                        r_hold_cnt    <= '0;
                        if (r_duty == ONE) r_phase <= BOT_NEXT;
                    end
                    HOLD_LO: begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_phase    <= UP;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_phase    <= UP;
                        r_hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign duty        = r_duty;
    assign duty_update = r_duty_update;
    assign phase       = r_phase;

endmodule

// File: doc/breath_ramp_gen.md
Name: breath_ramp_gen

Overview:
Upstream duty-level source for the LED PWM stage. Generates a triangular "breathing" brightness sequence: ramp up, hold at max, ramp down, hold at zero, repeat. Steps are paced by a programmable prescaler. Its duty output drives the PWM comparator's level input directly, replacing a raw counter slice with an explicit state machine and configurable timing.

Parameters:
DUTY_W, 4, width of duty output; MAX = 2^DUTY_W - 1
PRESCALE_DIV, 4194304, clk cycles per step tick (>= 2)
HOLD_TICKS, 4, ticks spent at MAX and at 0 (0 = no hold, direct reversal)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  1 = advance; 0 = freeze prescaler, FSM and duty
restart  in  1  synchronous; returns to reset state on next edge, priority over enable
duty  out  DUTY_W  current brightness level to PWM stage, registered
duty_update  out  1  one-cycle pulse in the cycle duty takes a new value
phase  out  2  current FSM state encoding, registered

Behaviour:
- Clock/reset: one clock, clk. Reset asynchronous, active-high. While reset is high: duty=0, duty_update=0, phase=UP, pre_cnt=0, hold_cnt=0.
- Prescaler: pre_cnt counts 0..PRESCALE_DIV-1 while enable=1. tick=1 when pre_cnt==PRESCALE_DIV-1 and enable=1; pre_cnt then wraps to 0. With enable=0, pre_cnt holds its value (not cleared) and tick=0.
- restart=1: next edge forces the reset state (pre_cnt, hold_cnt, duty=0, phase=UP). duty_update=1 only if duty was nonzero. Overrides enable and tick in the same cycle.
- FSM states: UP=0, HOLD_HI=1, DOWN=2, HOLD_LO=3. All transitions occur only on tick.
- UP: duty <= duty+1, duty_update pulses. If the old duty==MAX-1, go to HOLD_HI, or to DOWN if HOLD_TICKS==0. hold_cnt <= 0.
- HOLD_HI: if hold_cnt==HOLD_TICKS-1, go to DOWN and set hold_cnt <= 0; else hold_cnt+1. duty unchanged.
- DOWN: duty <= duty-1, duty_update pulses. If the old duty==1, go to HOLD_LO, or to UP if HOLD_TICKS==0. hold_cnt <= 0.
- HOLD_LO: mirror of HOLD_HI, exits to UP.
- Range: duty never wraps. It stays in 0..MAX, and arithmetic is DUTY_W-bit with no overflow by construction.
- Latency: duty, phase and duty_update change on the edge that samples tick=1. duty_update is high exactly one cycle per change.
- Period: 2*MAX + 2*HOLD_TICKS ticks per full breath (38 ticks at defaults).
- Reset mid-operation: immediate return to reset values regardless of state. The first tick after release happens PRESCALE_DIV cycles later.
- enable toggling: freeze and resume are lossless. The resumed tick position continues from the frozen pre_cnt.
- hold_cnt width: clog2(HOLD_TICKS+1), minimum 1 bit. pre_cnt width: clog2(PRESCALE_DIV).

Decomposition:
- Shared package breath_pkg holds:
  - the phase state encoding constants (UP, HOLD_HI, DOWN, HOLD_LO, 2-bit);
  - the DUTY_W default.
- One sub-module is natural: tick_prescaler (clk, reset, enable, clear → tick), parameterised by PRESCALE_DIV. It is reusable by other LED stages.
- The FSM and duty register stay in breath_ramp_gen.

Test Plan:
- Reset check: set PRESCALE_DIV=4, DUTY_W=4, HOLD_TICKS=2, and assert reset mid-run. Required: duty=0, phase=0 and duty_update=0 immediately, without waiting for a clk edge. After release with enable=1, the first duty_update occurs 4 cycles later with duty=1.
- Full cycle, same params: duty sequence over ticks is 1..15, then 15,15 (HOLD_HI), then 14..0, then 0,0 (HOLD_LO), then 1. Period is 34 ticks = 136 clks, and duty_update pulses exactly 30 times.
- HOLD_TICKS=0: duty goes 14, 15, 14 on consecutive ticks, and 1, 0, 1 at the bottom. phase skips 1 and 3.
- enable low for 10 cycles at pre_cnt=2: no duty change while low. The next tick arrives 1 cycle after enable returns high.
- restart asserted with duty=9 in DOWN, same cycle as tick and enable=1: next cycle duty=0, phase=UP and duty_update=1. The next tick is 4 cycles later, giving duty=1.
- restart asserted while duty=0 in HOLD_LO: duty_update stays 0 and phase becomes UP.
